// File: rtl/apu_pulse_pkg.sv
// Shared types and constants for the APU pulse sequencer bank.
// Duty rows are stored with bit i = output at sequence position i.
package apu_pulse_pkg;

    typedef logic [1:0] duty_t;

    localparam int SEQ_LEN         = 8;
    localparam int SEQ_IDX_W       = 3;
    localparam int MUTE_PERIOD_MIN = 8;

    // Row 3 is the inverted 25% pattern, so it starts high at position 0.
    localparam logic [3:0][SEQ_LEN-1:0] DUTY_TABLE = {
        8'b1111_1001,
        8'b0001_1110,
        8'b0000_0110,
        8'b0000_0010
    };

    function automatic logic duty_bit(input duty_t duty, input logic [SEQ_IDX_W-1:0] idx);
        return DUTY_TABLE[duty][idx];
    endfunction

endpackage

// File: rtl/apu_pulse_seq_ch.sv
// One pulse channel: period down-counter, 8-step sequencer and registered waveform bit.
// Optional ultrasonic mute is enabled with the APU_PULSE_MUTE_EN macro.
module apu_pulse_seq_ch
    import apu_pulse_pkg::*;
#(
    parameter int TIMER_W = 11
) (
    input  logic                 cpu_clk,
    input  logic                 reset_n,
    input  logic                 apu_tick,
    input  logic                 enable_i,
    input  duty_t                duty_i,
    input  logic [TIMER_W-1:0]   period_i,
    input  logic                 restart_i,
    output logic                 waveform_o,
    output logic                 step_o,
    output logic [SEQ_IDX_W-1:0] seq_idx_o
);

    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic [SEQ_IDX_W-1:0] idx_d;
    logic                 expire;
    logic                 mute;
    logic                 wave_d;

`ifdef APU_PULSE_MUTE_EN
    assign mute = (period_i < TIMER_W'(MUTE_PERIOD_MIN));
`else
    assign mute = 1'b0;
`endif

    always_comb begin
        expire  = apu_tick && (timer_q == '0);
        timer_d = timer_q;
        if (apu_tick) begin
            timer_d = expire ? period_i : (timer_q - TIMER_W'(1));
        end
    end

    // Restart takes priority over a same-cycle expiry; the timer reload is unaffected.
    always_comb begin
        idx_d = seq_idx_o;
        if (restart_i) begin
            idx_d = '0;
        end else if (expire) begin
            idx_d = seq_idx_o - SEQ_IDX_W'(1);
        end
    end

    assign wave_d = enable_i & duty_bit(duty_i, idx_d) & ~mute;

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q    <= '0;
            seq_idx_o  <= '0;
            waveform_o <= 1'b0;
            step_o     <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            seq_idx_o  <= idx_d;
            waveform_o <= wave_d;
            step_o     <= expire;
        end
    end

endmodule

// File: rtl/apu_pulse_seq_bank.sv
// Bank of NUM_CH independent pulse sequencers; packed per-channel buses are sliced here.
// Honours the APU_PULSE_MUTE_EN macro through the channel instances.
module apu_pulse_seq_bank
    import apu_pulse_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int TIMER_W = 11
) (
    input  logic                        cpu_clk,
    input  logic                        reset_n,
    input  logic                        apu_tick,
    input  logic [NUM_CH-1:0]           enable_i,
    input  logic [2*NUM_CH-1:0]         duty_i,
    input  logic [TIMER_W*NUM_CH-1:0]   period_i,
    input  logic [NUM_CH-1:0]           restart_i,
    output logic [NUM_CH-1:0]           waveform_o,
    output logic [NUM_CH-1:0]           step_o,
    output logic [3*NUM_CH-1:0]         seq_idx_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        apu_pulse_seq_ch #(
            .TIMER_W (TIMER_W)
        ) u_ch (
            .cpu_clk    (cpu_clk),
            .reset_n    (reset_n),
            .apu_tick   (apu_tick),
            .enable_i   (enable_i[c]),
            .duty_i     (duty_t'(duty_i[2*c +: 2])),
            .period_i   (period_i[TIMER_W*c +: TIMER_W]),
            .restart_i  (restart_i[c]),
            .waveform_o (waveform_o[c]),
            .step_o     (step_o[c]),
            .seq_idx_o  (seq_idx_o[SEQ_IDX_W*c +: SEQ_IDX_W])
        );
    end

endmodule

// File: tb/tb_apu_pulse_seq_bank.sv
// Self-checking bench for apu_pulse_seq_bank against a tick-countdown reference model.
// Build with or without APU_PULSE_MUTE_EN to match the RTL configuration.
module tb_apu_pulse_seq_bank;

    localparam int NCH = 2;
    localparam int TW  = 11;

    logic              cpu_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              apu_tick = 1'b0;
    logic [NCH-1:0]    enable_i = '0;
    logic [2*NCH-1:0]  duty_i = '0;
    logic [TW*NCH-1:0] period_i = '0;
    logic [NCH-1:0]    restart_i = '0;
    logic [NCH-1:0]    waveform_o;
    logic [NCH-1:0]    step_o;
    logic [3*NCH-1:0]  seq_idx_o;

    int tests = 0;
    int fails = 0;

    // Duty rows as written in the datasheet: entry [d][p] is the output at position p.
    int duty_row [4][8] = '{'{0,1,0,0,0,0,0,0},
                            '{0,1,1,0,0,0,0,0},
                            '{0,1,1,1,1,0,0,0},
                            '{1,0,0,1,1,1,1,1}};

    // Model state: ticks remaining until the next expiry, sequence position, outputs.
    int m_rem  [NCH];
    int m_idx  [NCH];
    int m_wave [NCH];
    int m_step [NCH];

    apu_pulse_seq_bank #(.NUM_CH(NCH), .TIMER_W(TW)) dut (
        .cpu_clk    (cpu_clk),
        .reset_n    (reset_n),
        .apu_tick   (apu_tick),
        .enable_i   (enable_i),
        .duty_i     (duty_i),
        .period_i   (period_i),
        .restart_i  (restart_i),
        .waveform_o (waveform_o),
        .step_o     (step_o),
        .seq_idx_o  (seq_idx_o)
    );

    initial forever #5 cpu_clk = ~cpu_clk;

    function automatic int is_muted(int p);
`ifdef APU_PULSE_MUTE_EN
        return (p < 8) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_rem[c] = 1; m_idx[c] = 0; m_wave[c] = 0; m_step[c] = 0;
        end
    endtask

    task automatic model_advance();
        for (int c = 0; c < NCH; c++) begin
            int p;
            int d;
            int ex;
            p  = int'(period_i[TW*c +: TW]);
            d  = int'(duty_i[2*c +: 2]);
            ex = 0;
            if (apu_tick) begin
                if (m_rem[c] == 1) begin
                    ex = 1;
                    m_rem[c] = p + 1;
                end else begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end
            if (restart_i[c]) m_idx[c] = 0;
            else if (ex != 0) m_idx[c] = (m_idx[c] + 7) % 8;
            m_step[c] = ex;
            m_wave[c] = (enable_i[c] && duty_row[d][m_idx[c]] == 1 && is_muted(p) == 0) ? 1 : 0;
        end
    endtask

    function automatic logic [NCH-1:0] exp_wave();
        for (int c = 0; c < NCH; c++) exp_wave[c] = (m_wave[c] != 0);
    endfunction

    function automatic logic [NCH-1:0] exp_step();
        for (int c = 0; c < NCH; c++) exp_step[c] = (m_step[c] != 0);
    endfunction

    function automatic logic [3*NCH-1:0] exp_idx();
        for (int c = 0; c < NCH; c++) exp_idx[3*c +: 3] = 3'(m_idx[c]);
    endfunction

    task automatic step_clk();
        model_advance();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge cpu_clk);
        #2 reset_n = 1'b1;
        model_reset();
        @(negedge cpu_clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (waveform_o !== '0 || step_o !== '0 || seq_idx_o !== '0) begin
            $display("FAIL reset_init wave=%b step=%b idx=%h required all 0", waveform_o, step_o, seq_idx_o);
            fails++;
        end
        enable_i = '1; duty_i = 4'b1110; period_i = {11'd1, 11'd0}; apu_tick = 1'b1;
        repeat (13) step_clk();
        tests++;
        if (seq_idx_o !== exp_idx()) begin
            $display("FAIL reset_prerun idx=%h required %h", seq_idx_o, exp_idx());
            fails++;
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (waveform_o !== '0 || step_o !== '0 || seq_idx_o !== '0) begin
            $display("FAIL reset_async wave=%b step=%b idx=%h required all 0", waveform_o, step_o, seq_idx_o);
            fails++;
        end
        repeat (3) @(posedge cpu_clk);
        #1;
        tests++;
        if (waveform_o !== '0 || step_o !== '0 || seq_idx_o !== '0) begin
            $display("FAIL reset_hold wave=%b step=%b idx=%h required all 0", waveform_o, step_o, seq_idx_o);
            fails++;
        end
        #2 reset_n = 1'b1;
        model_reset();
        step_clk();
        tests++;
        if (seq_idx_o !== exp_idx() || step_o !== exp_step() || waveform_o !== exp_wave()) begin
            $display("FAIL reset_release idx=%h step=%b wave=%b required %h %b %b",
                     seq_idx_o, step_o, waveform_o, exp_idx(), exp_step(), exp_wave());
            fails++;
        end
        apu_tick = 1'b0;
    endtask

    task automatic test_period3_duty2();
        int last;
        int ch0_idx;
        do_reset();
        last = -1;
        enable_i = 2'b11; duty_i = {2'($urandom_range(0, 3)), 2'd2};
        period_i = {11'($urandom_range(0, 20)), 11'd3};
        for (int cyc = 0; cyc < 80; cyc++) begin
            apu_tick = (cyc % 2 == 0);
            step_clk();
            tests++;
            if (waveform_o !== exp_wave() || step_o !== exp_step() || seq_idx_o !== exp_idx()) begin
                $display("FAIL p3d2 cyc=%0d wave=%b step=%b idx=%h required %b %b %h",
                         cyc, waveform_o, step_o, seq_idx_o, exp_wave(), exp_step(), exp_idx());
                fails++;
            end
            if (step_o[0]) begin
                if (last >= 0) begin
                    tests++;
                    if (cyc - last != 8) begin
                        $display("FAIL p3d2_interval got %0d cycles required 8", cyc - last);
                        fails++;
                    end
                end
                last = cyc;
            end
            ch0_idx = int'(seq_idx_o[2:0]);
            tests++;
            if (int'(waveform_o[0]) != duty_row[2][ch0_idx]) begin
                $display("FAIL p3d2_row idx=%0d wave=%0d required %0d", ch0_idx, waveform_o[0], duty_row[2][ch0_idx]);
                fails++;
            end
        end
        apu_tick = 1'b0;
    endtask

    task automatic test_all_duties();
        do_reset();
        enable_i = 2'b11; period_i = '0; apu_tick = 1'b1;
        for (int d = 0; d < 4; d++) begin
            duty_i = {2'(3 - d), 2'(d)};
            for (int k = 0; k < 8; k++) begin
                step_clk();
                tests++;
                if (waveform_o !== exp_wave() || seq_idx_o !== exp_idx() || step_o !== exp_step()) begin
                    $display("FAIL duty%0d k=%0d wave=%b idx=%h step=%b required %b %h %b",
                             d, k, waveform_o, seq_idx_o, step_o, exp_wave(), exp_idx(), exp_step());
                    fails++;
                end
            end
        end
        // Change duty mid-sequence; the new row must show on the very next edge.
        for (int k = 0; k < 6; k++) begin
            duty_i = 4'($urandom);
            step_clk();
            tests++;
            if (waveform_o !== exp_wave()) begin
                $display("FAIL duty_change k=%0d wave=%b required %b", k, waveform_o, exp_wave());
                fails++;
            end
        end
        apu_tick = 1'b0;
    endtask

    task automatic test_restart_expiry();
        do_reset();
        enable_i = 2'b11; duty_i = 4'b0110; period_i = {11'd4, 11'd2}; apu_tick = 1'b1;
        repeat (7) step_clk();
        for (int k = 0; k < 6 && m_rem[0] != 1; k++) step_clk();
        tests++;
        if (m_rem[0] != 1 || seq_idx_o[2:0] === 3'd0) begin
            $display("FAIL restart_setup rem=%0d idx=%0d required rem 1, idx nonzero", m_rem[0], seq_idx_o[2:0]);
            fails++;
        end
        restart_i = 2'b01;
        step_clk();
        restart_i = 2'b00;
        tests++;
        if (seq_idx_o[2:0] !== 3'd0 || step_o[0] !== 1'b1) begin
            $display("FAIL restart_same_cycle idx=%0d step=%b required idx 0 step 1", seq_idx_o[2:0], step_o[0]);
            fails++;
        end
        for (int k = 0; k < 2; k++) begin
            step_clk();
            tests++;
            if (step_o[0] !== 1'b0) begin
                $display("FAIL restart_reload k=%0d step=%b required 0", k, step_o[0]);
                fails++;
            end
        end
        step_clk();
        tests++;
        if (step_o[0] !== 1'b1 || seq_idx_o[2:0] !== 3'd7) begin
            $display("FAIL restart_next_exp step=%b idx=%0d required step 1 idx 7", step_o[0], seq_idx_o[2:0]);
            fails++;
        end
        tests++;
        if (waveform_o !== exp_wave() || seq_idx_o !== exp_idx()) begin
            $display("FAIL restart_model wave=%b idx=%h required %b %h", waveform_o, seq_idx_o, exp_wave(), exp_idx());
            fails++;
        end
        apu_tick = 1'b0;
    endtask

    task automatic test_two_channels();
        logic [2:0] ch0_before;
        do_reset();
        enable_i = 2'b11; period_i = {11'd9, 11'd5};
        duty_i = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        for (int cyc = 0; cyc < 300; cyc++) begin
            apu_tick = (cyc % 2 == 0);
            ch0_before = seq_idx_o[2:0];
            restart_i = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            if (cyc == 150) duty_i = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            step_clk();
            tests++;
            if (waveform_o !== exp_wave() || step_o !== exp_step() || seq_idx_o !== exp_idx()) begin
                $display("FAIL two_ch cyc=%0d wave=%b step=%b idx=%h required %b %b %h",
                         cyc, waveform_o, step_o, seq_idx_o, exp_wave(), exp_step(), exp_idx());
                fails++;
            end
            if (restart_i[1] && !step_o[0]) begin
                tests++;
                if (seq_idx_o[2:0] !== ch0_before) begin
                    $display("FAIL two_ch_crosstalk ch0 idx=%0d required %0d", seq_idx_o[2:0], ch0_before);
                    fails++;
                end
            end
        end
        restart_i = '0; apu_tick = 1'b0;
    endtask

    task automatic test_mute();
        int ones0, ones1, steps0;
        do_reset();
        ones0 = 0; ones1 = 0; steps0 = 0;
        enable_i = 2'b11; duty_i = 4'b1010; period_i = {11'd8, 11'd7}; apu_tick = 1'b1;
        for (int cyc = 0; cyc < 160; cyc++) begin
            step_clk();
            tests++;
            if (waveform_o !== exp_wave() || step_o !== exp_step()) begin
                $display("FAIL mute cyc=%0d wave=%b step=%b required %b %b", cyc, waveform_o, step_o, exp_wave(), exp_step());
                fails++;
            end
            ones0 += int'(waveform_o[0]);
            ones1 += int'(waveform_o[1]);
            steps0 += int'(step_o[0]);
        end
        tests++;
`ifdef APU_PULSE_MUTE_EN
        if (ones0 != 0 || ones1 == 0 || steps0 != 20) begin
            $display("FAIL mute_summary p7_high=%0d p8_high=%0d p7_steps=%0d required 0, >0, 20", ones0, ones1, steps0);
            fails++;
        end
`else
        if (ones0 == 0 || ones1 == 0 || steps0 != 20) begin
            $display("FAIL mute_summary p7_high=%0d p8_high=%0d p7_steps=%0d required >0, >0, 20", ones0, ones1, steps0);
            fails++;
        end
`endif
        apu_tick = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            apu_tick  = ($urandom_range(0, 2) != 0);
            restart_i = ($urandom_range(0, 31) == 0) ? NCH'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) enable_i = NCH'($urandom);
            if ($urandom_range(0, 31) == 0) duty_i = (2*NCH)'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                for (int c = 0; c < NCH; c++) period_i[TW*c +: TW] = TW'($urandom_range(0, 12));
            end
            step_clk();
            tests++;
            if (waveform_o !== exp_wave() || step_o !== exp_step() || seq_idx_o !== exp_idx()) begin
                $display("FAIL random cyc=%0d wave=%b step=%b idx=%h required %b %b %h",
                         cyc, waveform_o, step_o, seq_idx_o, exp_wave(), exp_step(), exp_idx());
                fails++;
            end
        end
        restart_i = '0; apu_tick = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge cpu_clk);
        test_reset();
        test_period3_duty2();
        test_all_duties();
        test_restart_expiry();
        test_two_channels();
        test_mute();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
